// File: rtl/fpu16_req_ctrl_if.sv
// Command/response handshake bundle between an issuer and fpu16_req_ctrl.
// The master side issues commands and consumes responses; the slave side is the controller.
interface fpu16_req_ctrl_if #(
  parameter int TAG_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [15:0]      cmd_a;
  logic [15:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_result;
  logic [3:0]       rsp_cond;
  logic [4:0]       rsp_flags;
  logic [2:0]       rsp_comps;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_cond, rsp_flags, rsp_comps,
           rsp_tag, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_cond, rsp_flags, rsp_comps,
           rsp_tag, rsp_timeout
  );
endinterface

// File: rtl/fpu16_req_ctrl.sv
// Request-side controller for fpu16: takes one command, drives the FPU, waits for
// multi-cycle ops (with a timeout) and hands the captured results back.
`ifndef FP16_NAN
`define FP16_NAN 16'h7E00
`endif

module fpu16_req_ctrl #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  fpu16_req_ctrl_if.slave        bus,
  output logic [15:0]            fpuIn1,
  output logic [15:0]            fpuIn2,
  output logic [1:0]             op,
  output logic                   start,
  input  logic [15:0]            fpuOut,
  input  logic                   mulDone,
  input  logic                   divDone,
  input  logic [3:0]             condCodes,
  input  logic [4:0]             statusFlags,
  input  logic [2:0]             comps,
  output logic                   busy
);

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_MUL = 2'd2,
    FPU_DIV = 2'd3
  } fpuOp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ctrlState_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  ctrlState_t       state, nextState;
  fpuOp_t           opReg;
  logic [15:0]      aReg, bReg;
  logic [TAG_W-1:0] tagReg;
  logic [CNT_W-1:0] waitCnt;
  logic [15:0]      resultReg;
  logic [3:0]       condReg;
  logic [4:0]       flagsReg;
  logic [2:0]       compsReg;
  logic             timeoutReg;

  logic isLong, opDone, timeoutHit, accept;

  // Only the done line belonging to the registered op matters; the other is ignored.
  assign isLong     = (opReg == FPU_MUL) || (opReg == FPU_DIV);
  assign opDone     = (opReg == FPU_MUL) ? mulDone : divDone;
  assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 2));
  assign accept     = (state == IDLE) && bus.cmd_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (bus.cmd_valid) nextState = ISSUE;
      ISSUE: nextState = isLong ? WAIT : RESP;
      WAIT:  if (opDone || timeoutHit) nextState = RESP;
      RESP:  if (bus.rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opReg      <= FPU_ADD;
      aReg       <= '0;
      bReg       <= '0;
      tagReg     <= '0;
      waitCnt    <= '0;
      resultReg  <= '0;
      condReg    <= '0;
      flagsReg   <= '0;
      compsReg   <= '0;
      timeoutReg <= 1'b0;
    end else begin
      if (accept) begin
        opReg  <= fpuOp_t'(bus.cmd_op);
        aReg   <= bus.cmd_a;
        bReg   <= bus.cmd_b;
        tagReg <= bus.cmd_tag;
      end

      if (state == ISSUE)
        waitCnt <= '0;
      else if ((state == WAIT) && !opDone)
        waitCnt <= waitCnt + 1'b1;

      // A done in the final wait cycle wins over the timeout abort.
      if (((state == ISSUE) && !isLong) || ((state == WAIT) && opDone)) begin
        resultReg  <= fpuOut;
        condReg    <= condCodes;
        flagsReg   <= statusFlags;
        compsReg   <= comps;
        timeoutReg <= 1'b0;
      end else if ((state == WAIT) && timeoutHit) begin
        resultReg  <= `FP16_NAN;
        condReg    <= '0;
        flagsReg   <= 5'b10000;
        compsReg   <= comps;
        timeoutReg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.cmd_ready   = (state == IDLE);
    bus.rsp_valid   = (state == RESP);
    busy            = (state != IDLE);
    start           = (state == ISSUE) && isLong;
    fpuIn1          = aReg;
    fpuIn2          = bReg;
    op              = opReg;
    bus.rsp_result  = resultReg;
    bus.rsp_cond    = condReg;
    bus.rsp_flags   = flagsReg;
    bus.rsp_comps   = compsReg;
    bus.rsp_tag     = tagReg;
    bus.rsp_timeout = timeoutReg;
  end

endmodule

// File: tb/tb_fpu16_req_ctrl.sv
// Self-checking bench for fpu16_req_ctrl; the bench plays fpu16 and checks every
// response against a transaction-level model of what should be captured.
module tb_fpu16_req_ctrl;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [15:0] NAN_VAL = 16'h7E00;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] fpuIn1, fpuIn2, fOut;
  logic [1:0]  op;
  logic        start, busy, fMul, fDiv;
  logic [3:0]  fCond;
  logic [4:0]  fFlags;
  logic [2:0]  fComps;

  int checkCount = 0;
  int errCount   = 0;

  fpu16_req_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpu16_req_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .op(op), .start(start),
    .fpuOut(fOut), .mulDone(fMul), .divDone(fDiv),
    .condCodes(fCond), .statusFlags(fFlags), .comps(fComps), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Stand-in for fpu16: packs {flags, cond, comps, result}; a few known values plus a fixed mix.
  function automatic logic [27:0] fpuModel(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0]  fl;
    logic [3:0]  cc;
    logic [2:0]  cp;
    r  = (a ^ {b[7:0], b[15:8]}) + {14'd0, o};
    fl = a[4:0] ^ b[9:5];
    cc = a[15:12] ^ {2'b00, o};
    cp = b[2:0];
    if (o == 2'd0 && a == 16'h3C00 && b == 16'h4000) begin r = 16'h4200; fl = 5'd0; end
    if (o == 2'd2 && a == 16'h4200 && b == 16'h4000) begin r = 16'h4600; fl = 5'd0; end
    if (o == 2'd3 && b == 16'h0000) begin r = 16'h7C00; fl = 5'b01000; end
    return {fl, cc, cp, r};
  endfunction

  task automatic driveGarbage();
    fOut   = 16'($urandom);
    fCond  = 4'($urandom);
    fFlags = 5'($urandom);
    fComps = 3'($urandom);
    fMul   = 1'($urandom);
    fDiv   = 1'($urandom);
  endtask

  task automatic driveIgnoredCmd(input logic v);
    bus.cmd_valid = v;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_a     = 16'($urandom);
    bus.cmd_b     = 16'($urandom);
    bus.cmd_tag   = TAG_W'($urandom);
  endtask

  // One complete transaction. doneDelay = WAIT cycle index carrying done (-1: never); stall = rsp_ready-low cycles.
  task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                               input logic [TAG_W-1:0] t, input int doneDelay, input int stall);
    logic [27:0] m;
    logic [15:0] expRes;
    logic [4:0]  expFlags;
    logic [3:0]  expCond;
    logic [2:0]  expComps;
    logic        expTo;
    logic        isLong;
    int          guard;
    m      = fpuModel(o, a, b);
    isLong = o[1];
    guard  = 0;
    while (!bus.cmd_ready && guard < 200) begin tick(); guard++; end
    checkOutput("cmdReadyBeforeAccept", bus.cmd_ready, 1);

    bus.cmd_valid = 1'b1; bus.cmd_op = o; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_tag = t;
    bus.rsp_ready = 1'b0;
    driveGarbage();
    tick();
    driveIgnoredCmd(1'($urandom));

    checkOutput("issueBusy", busy, 1);
    checkOutput("issueCmdReady", bus.cmd_ready, 0);
    checkOutput("issueRspValid", bus.rsp_valid, 0);
    checkOutput("issueStart", start, isLong);
    checkOutput("issueIn1", fpuIn1, a);
    checkOutput("issueIn2", fpuIn2, b);
    checkOutput("issueOp", op, o);

    expTo = 1'b0;
    {expFlags, expCond, expComps, expRes} = m;
    if (!isLong) begin
      driveGarbage();
      {fFlags, fCond, fComps, fOut} = m;
      tick();
    end else begin
      driveGarbage();
      tick();
      for (int k = 0; k < TIMEOUT; k++) begin
        checkOutput("waitStart", start, 0);
        checkOutput("waitRspValid", bus.rsp_valid, 0);
        checkOutput("waitIn1", fpuIn1, a);
        checkOutput("waitOp", op, o);
        driveGarbage();
        driveIgnoredCmd(1'($urandom));
        if (o == 2'd2) fMul = 1'b0; else fDiv = 1'b0;
        if (k == doneDelay) begin
          {fFlags, fCond, fComps, fOut} = m;
          if (o == 2'd2) fMul = 1'b1; else fDiv = 1'b1;
          tick();
          break;
        end else if (k == TIMEOUT - 2) begin
          expTo = 1'b1; expRes = NAN_VAL; expFlags = 5'b10000; expCond = 4'd0; expComps = fComps;
          tick();
          break;
        end
        tick();
      end
    end

    for (int s = 0; s <= stall; s++) begin
      checkOutput("respValid", bus.rsp_valid, 1);
      checkOutput("respCmdReady", bus.cmd_ready, 0);
      checkOutput("respStart", start, 0);
      checkOutput("respResult", bus.rsp_result, expRes);
      checkOutput("respFlags", bus.rsp_flags, expFlags);
      checkOutput("respCond", bus.rsp_cond, expCond);
      checkOutput("respComps", bus.rsp_comps, expComps);
      checkOutput("respTag", bus.rsp_tag, t);
      checkOutput("respTimeout", bus.rsp_timeout, expTo);
      checkOutput("respIn2", fpuIn2, b);
      driveGarbage();
      driveIgnoredCmd(1'b1);
      bus.rsp_ready = (s == stall);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checkOutput("afterRspValid", bus.rsp_valid, 0);
    checkOutput("afterCmdReady", bus.cmd_ready, 1);
    checkOutput("afterBusy", busy, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = 16'd0; bus.cmd_b = 16'd0;
    bus.cmd_tag = '0; bus.rsp_ready = 1'b0;
    driveGarbage();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rstCmdReady", bus.cmd_ready, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstStart", start, 0);
    checkOutput("rstRspValid", bus.rsp_valid, 0);
    checkOutput("rstRspResult", bus.rsp_result, 0);
    checkOutput("rstRspTimeout", bus.rsp_timeout, 0);
    checkOutput("rstIn1", fpuIn1, 0);
    checkOutput("rstOp", op, 0);
    reset = 1'b0;
    tick();

    $display("[TB] directed operations");
    applyStimulus(2'd0, 16'h3C00, 16'h4000, 4'd3, 0, 0);
    applyStimulus(2'd2, 16'h4200, 16'h4000, 4'd5, 4, 0);
    applyStimulus(2'd3, 16'h3C00, 16'h0000, 4'd9, 3, 1);
    applyStimulus(2'd3, 16'h1234, 16'h5678, 4'd7, -1, 0);
    applyStimulus(2'd3, 16'h2345, 16'h6789, 4'd8, TIMEOUT - 2, 0);
    applyStimulus(2'd1, 16'hABCD, 16'h1357, 4'd1, 0, 5);
    applyStimulus(2'd2, 16'h0F0F, 16'hF0F0, 4'd2, 0, 2);

    $display("[TB] reset during WAIT");
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_a = 16'h4400; bus.cmd_b = 16'h4100;
    bus.cmd_tag = 4'd6;
    driveGarbage();
    fMul = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    checkOutput("rwStart", start, 1);
    fMul = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rwBusy", busy, 0);
    checkOutput("rwRspValid", bus.rsp_valid, 0);
    checkOutput("rwStart2", start, 0);
    checkOutput("rwCmdReady", bus.cmd_ready, 1);
    checkOutput("rwIn1", fpuIn1, 0);
    checkOutput("rwRspResult", bus.rsp_result, 0);
    for (int i = 0; i < 4; i++) begin
      driveGarbage();
      fMul = 1'b1;
      tick();
      checkOutput("rwNoResponse", bus.rsp_valid, 0);
    end
    applyStimulus(2'd0, 16'h3C00, 16'h4000, 4'd12, 0, 0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      logic [1:0] ro;
      int dly;
      ro  = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      applyStimulus(ro, 16'($urandom), 16'($urandom), TAG_W'($urandom), dly, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
